// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register with a 2-entry skid buffer and valid/ready handshake.
// in_ready is registered, so a stall is absorbed by the skid entry and no word is lost.
module pipe_stage_skid_reg #(
  parameter int                 DATA_W         = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL     = {DATA_W{1'b0}},
  parameter bit                 CLEAR_ON_EMPTY = 1'b1,
  parameter int                 CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]   main_r, main_nxt_s;
  logic [DATA_W-1:0]   skid_r, skid_nxt_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [1:0]          occupancy_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                in_xfer_s;
  logic                stall_inc_s;

  function automatic logic [1:0] occ_of(input state_t st);
    case (st)
      ST_EMPTY: occ_of = 2'd0;
      ST_ONE:   occ_of = 2'd1;
      ST_TWO:   occ_of = 2'd2;
      default:  occ_of = 2'd0;
    endcase
  endfunction

  assign in_xfer_s   = in_valid & in_ready_r;
  assign stall_inc_s = out_valid_r & ~out_ready & (stall_cnt_r != CNT_MAX);

  // Next-state and payload routing; main always holds the older word.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = in_data;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_xfer_s && out_ready) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = in_data;
        end else if (in_xfer_s) begin
          state_nxt_s = ST_TWO;
          skid_nxt_s  = in_data;
        end else if (out_ready) begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = CLEAR_ON_EMPTY ? BUBBLE_VAL : main_r;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = skid_r;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
        main_nxt_s  = BUBBLE_VAL;
        skid_nxt_s  = BUBBLE_VAL;
      end
    endcase
  end

  // State, payload and status registers; flush keeps the stall count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_r      <= BUBBLE_VAL;
      skid_r      <= BUBBLE_VAL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      main_r      <= BUBBLE_VAL;
      skid_r      <= BUBBLE_VAL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occupancy_r <= occ_of(state_nxt_s);
      if (stall_inc_s) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occupancy_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: queue-based reference model checked every cycle,
// an in/out order scoreboard, and directed vectors with literal expectations.
module tb_pipe_stage_skid_reg;

  localparam int          DW      = 32;
  localparam int          CW      = 4;
  localparam logic [31:0] BUBBLE  = 32'h0;
  localparam int          STL_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(
    .DATA_W(DW), .BUBBLE_VAL(BUBBLE), .CLEAR_ON_EMPTY(1'b1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two words.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data;
  bit            m_ready;
  int            m_stall;
  bit            m_live = 1'b0;

  always @(posedge clk) begin : model
    bit acc;
    acc = in_valid && m_ready;
    if (rst) begin
      mq.delete(); m_data = BUBBLE; m_ready = 1'b1; m_stall = 0; m_live = 1'b1;
    end else if (flush) begin
      mq.delete(); m_data = BUBBLE; m_ready = 1'b1;
    end else begin
      if (mq.size() > 0 && !out_ready && m_stall < STL_MAX) m_stall++;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      m_data  = (mq.size() > 0) ? mq[0] : BUBBLE;
      m_ready = (mq.size() < 2);
    end
  end

  // Per-cycle compare plus order scoreboard on the handshakes of the coming edge.
  logic [DW-1:0] sbq[$];
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("out_data", out_data, m_data);
      chk("in_ready", in_ready, m_ready);
      chk("occupancy", occupancy, mq.size());
      chk("stall_cnt", stall_cnt, m_stall);
      if (rst || flush) begin
        sbq.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
          else chk("sb_order", out_data, sbq.pop_front());
        end
        if (in_valid && in_ready) sbq.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    bit acc_prev;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
    // 1: reset
    step(); step();
    chk("rst_valid", out_valid, 1'b0); chk("rst_data", out_data, 32'h0);
    chk("rst_ready", in_ready, 1'b1);  chk("rst_occ", occupancy, 2'd0);
    chk("rst_stall", stall_cnt, 4'd0);
    rst = 1'b0;
    // 2: streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'h11; step(); chk("s_11", out_data, 32'h11); chk("s_occ1", occupancy, 2'd1);
    in_data = 32'h22; step(); chk("s_22", out_data, 32'h22); chk("s_rdy", in_ready, 1'b1);
    in_data = 32'h33; step(); chk("s_33", out_data, 32'h33); chk("s_occ3", occupancy, 2'd1);
    in_valid = 1'b0; step(); chk("s_drain", out_valid, 1'b0); chk("s_bub", out_data, 32'h0);
    // 3: back-pressure into the skid entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; step(); chk("bp_A", out_data, 32'hA);
    in_data = 32'hB; step(); chk("bp_occ2", occupancy, 2'd2); chk("bp_rdy0", in_ready, 1'b0);
    in_data = 32'hC; step(); chk("bp_hold", out_data, 32'hA); chk("bp_occ2b", occupancy, 2'd2);
    out_ready = 1'b1; step(); chk("bp_B", out_data, 32'hB); chk("bp_rdy1", in_ready, 1'b1);
    step(); chk("bp_C", out_data, 32'hC); chk("bp_occ1", occupancy, 2'd1);
    in_valid = 1'b0; step(); chk("bp_empty", out_valid, 1'b0);
    // 4: flush with a full stage and a word on the input
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h1; step();
    in_data = 32'h2; step(); chk("fl_occ2", occupancy, 2'd2);
    in_data = 32'hD; flush = 1'b1; step(); flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 1'b0); chk("fl_data", out_data, 32'h0);
    chk("fl_occ", occupancy, 2'd0); chk("fl_rdy", in_ready, 1'b1);
    chk("fl_stall", stall_cnt, 4'd3);
    out_ready = 1'b1; step(); chk("fl_noD", out_valid, 1'b0);
    // 5: stall counter saturation
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5; step(); in_valid = 1'b0;
    repeat (20) step();
    chk("sat_15", stall_cnt, 4'd15);
    flush = 1'b1; step(); flush = 1'b0;
    chk("sat_flush", stall_cnt, 4'd15);
    rst = 1'b1; step(); rst = 1'b0;
    chk("sat_rst", stall_cnt, 4'd0);
    // 6: reset beats flush mid-stream, then random soak
    in_valid = 1'b1; in_data = 32'h6; step(); in_data = 32'h7; step();
    chk("r6_occ2", occupancy, 2'd2);
    rst = 1'b1; flush = 1'b1; in_data = 32'h8; step(); rst = 1'b0; flush = 1'b0;
    chk("r6_valid", out_valid, 1'b0); chk("r6_occ", occupancy, 2'd0);
    chk("r6_rdy", in_ready, 1'b1); chk("r6_data", out_data, 32'h0);
    in_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      acc_prev = in_valid && in_ready;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc_prev) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = $urandom;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("soak_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
